demux1to2_stream: RTL and testbench
===================================

DEMUX1TO2_STREAM -- requirements
Module: demux1to2_stream

Interface
- REQ-001 SHALL have parameter DATA_WITH, default 8: width of every data path.
- REQ-002 SHALL have port i_clk, input, 1: the only clock; all state updates on its rising edge.
- REQ-003 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
- REQ-004 SHALL have port i_data, input, DATA_WITH: upstream beat payload.
- REQ-005 SHALL have port i_sel, input, 1: destination of the upstream beat (0 -> port 0, 1 -> port 1), sampled with i_data.
- REQ-006 SHALL have port i_valid, input, 1: upstream beat present.
- REQ-007 SHALL have port o_ready, output, 1: block accepts the upstream beat this cycle.
- REQ-008 SHALL have ports o_y_0 and o_y_1, output, DATA_WITH each: payload of port 0 and port 1.
- REQ-009 SHALL have ports o_valid_0 and o_valid_1, output, 1 each: port holds a beat.
- REQ-010 SHALL have ports i_ready_0 and i_ready_1, input, 1 each: downstream consumer takes the held beat.
- REQ-011 SHALL, with DEMUX_CNT_EN defined, have ports o_cnt_0 and o_cnt_1, output, 16 each: beats delivered per port.

Function
- REQ-012 SHALL accept an upstream beat when i_valid && o_ready at a rising edge.
- REQ-013 SHALL drive o_ready = !o_valid_s || i_ready_s, where s = i_sel; the result is combinational from i_sel, o_valid_x and i_ready_x, and never depends on i_valid.
- REQ-014 SHALL load the accepted i_data into the one-entry register of port i_sel and set that port's o_valid on the same edge; latency from acceptance to output is 1 cycle.
- REQ-015 SHALL treat a port beat as delivered when o_valid_x && i_ready_x at an edge; o_valid_x clears unless a new beat is loaded to x on that same edge.
- REQ-016 SHALL, when a port delivers and is reloaded on the same edge, keep o_valid_x high and present the new data: full throughput of 1 beat/cycle per port.
- REQ-017 SHALL hold o_y_x and o_valid_x stable while o_valid_x && !i_ready_x.
- REQ-018 SHALL leave the non-selected port untouched by an accept; both ports drain independently, and a stalled port never blocks beats to the other port.
- REQ-019 SHALL not change o_y_x while o_valid_x is low, except by a load.
- REQ-020 SHALL ignore i_data and i_sel when i_valid is low.

Reset
- REQ-021 SHALL, with i_rst high at an edge, clear o_valid_0, o_valid_1, o_y_0, o_y_1 (and o_cnt_0, o_cnt_1 if present) to 0; in-flight beats are discarded.
- REQ-022 SHALL not accept a beat on an edge where i_rst is high, and SHALL hold o_ready high during reset.

Configuration
- REQ-023 SHALL, with macro DEMUX_CNT_EN defined, increment o_cnt_x by 1 on each delivery at port x; the count wraps 16'hFFFF -> 16'h0000.
- REQ-024 SHALL, without DEMUX_CNT_EN, omit the o_cnt ports and the counter logic entirely; all other behaviour is identical.

Structure
- REQ-025 SHALL place in package demux_pkg: localparam CNT_W = 16 and the enum port_e {PORT_0, PORT_1}.
- REQ-026 SHALL implement each port as sub-module demux_out_stage (one-entry register, load/deliver logic, optional counter), instantiated twice.

Verification
- REQ-027 Reset and first beat: i_rst high for 2 cycles, then i_data=8'hA5, i_sel=0, i_valid=1 for 1 cycle, i_ready_0=1 -> o_valid_0=1 with o_y_0=8'hA5 on the next cycle only; o_valid_1 stays 0.
- REQ-028 Back-to-back beats: 8'h01..8'h04 alternating i_sel 0/1/0/1, both readies high -> o_ready high throughout; port 0 shows 01, 03 and port 1 shows 02, 04, each one cycle after acceptance.
- REQ-029 Port stall isolation: i_ready_0=0 with 8'h11 held on port 0; send i_sel=0, 8'h22 -> o_ready=0 and o_y_0 stays 8'h11; send i_sel=1, 8'h33 -> accepted and o_y_1=8'h33.
- REQ-030 Simultaneous deliver and reload: port 0 holds 8'h44 with i_ready_0=1, new beat 8'h55 to port 0 on the same edge -> o_valid_0 stays 1 and o_y_0=8'h55.
- REQ-031 Reset mid-operation: both ports full and stalled, i_rst pulsed for 1 cycle -> both o_valid=0 and o_y=0 next cycle; the earlier data never appears.
- REQ-032 Counter wrap (DEMUX_CNT_EN): 65537 deliveries on port 1 -> o_cnt_1=16'h0001 and o_cnt_0=16'h0000.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer.
// Optional delivery counters are enabled by defining DEMUX_CNT_EN.
package demux_pkg;

    // Width of the per-port delivery counters.
    localparam int CNT_W = 16;

    // Destination port encoding, matching the i_sel input value.
    typedef enum logic {
        PORT_0 = 1'b0,
        PORT_1 = 1'b1
    } port_e;

endpackage

// File: rtl/demux_out_stage.sv
// One output port of the demultiplexer: a one-entry holding register with
// load/deliver handshake and, when DEMUX_CNT_EN is defined, a wrapping
// delivery counter.
module demux_out_stage
    import demux_pkg::*;
#(
    parameter int DATA_WITH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load,
    input  logic [DATA_WITH-1:0] i_data,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [DATA_WITH-1:0] o_y
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0]     o_cnt
`endif
);

    logic                 r_valid;
    logic [DATA_WITH-1:0] r_y;
    logic                 w_deliver;

    assign w_deliver = r_valid && i_ready;

    // Holding register: a load wins over a delivery so reload keeps valid high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_y     <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_y     <= i_data;
        end else if (w_deliver) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_y     = r_y;

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Delivery counter, wraps naturally at the counter width.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_deliver) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
`endif

endmodule

// File: rtl/demux1to2_stream.sv
// 1-to-2 valid/ready stream demultiplexer. Each upstream beat is routed by
// i_sel to one of two independently draining one-entry output stages.
// Optional per-port delivery counters: define DEMUX_CNT_EN.
module demux1to2_stream
    import demux_pkg::*;
#(
    parameter int DATA_WITH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DATA_WITH-1:0] i_data,
    input  logic                 i_sel,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [DATA_WITH-1:0] o_y_0,
    output logic [DATA_WITH-1:0] o_y_1,
    output logic                 o_valid_0,
    output logic                 o_valid_1,
    input  logic                 i_ready_0,
    input  logic                 i_ready_1
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0]     o_cnt_0,
    output logic [CNT_W-1:0]     o_cnt_1
`endif
);

    port_e w_sel;
    logic  w_ready;
    logic  w_accept;
    logic  w_load_0;
    logic  w_load_1;

    assign w_sel = port_e'(i_sel);

    // Ready depends only on the selected port's state, never on i_valid;
    // it is forced high during reset while accepts are blocked.
    always_comb begin
        w_ready  = 1'b0;
        w_accept = 1'b0;
        w_load_0 = 1'b0;
        w_load_1 = 1'b0;
        case (w_sel)
            PORT_0:  w_ready = !o_valid_0 || i_ready_0;
            PORT_1:  w_ready = !o_valid_1 || i_ready_1;
            default: w_ready = 1'b0;
        endcase
        w_accept = i_valid && w_ready && !i_rst;
        w_load_0 = w_accept && (w_sel == PORT_0);
        w_load_1 = w_accept && (w_sel == PORT_1);
    end

    assign o_ready = i_rst || w_ready;

    demux_out_stage #(
        .DATA_WITH (DATA_WITH)
    ) u_stage_0 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_load_0),
        .i_data  (i_data),
        .i_ready (i_ready_0),
        .o_valid (o_valid_0),
        .o_y     (o_y_0)
`ifdef DEMUX_CNT_EN
        ,
        .o_cnt   (o_cnt_0)
`endif
    );

    demux_out_stage #(
        .DATA_WITH (DATA_WITH)
    ) u_stage_1 (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_load_1),
        .i_data  (i_data),
        .i_ready (i_ready_1),
        .o_valid (o_valid_1),
        .o_y     (o_y_1)
`ifdef DEMUX_CNT_EN
        ,
        .o_cnt   (o_cnt_1)
`endif
    );

endmodule

// File: tb/tb_demux1to2_stream.sv
// Testbench for demux1to2_stream: directed scenarios plus randomized traffic
// checked against a queue-based model of two one-deep output buffers.
// Counter checks are compiled in when DEMUX_CNT_EN is defined.
module tb_demux1to2_stream;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data;
    logic          sel;
    logic          valid;
    logic          o_ready;
    logic [DW-1:0] y0, y1;
    logic          v0, v1;
    logic          rdy0, rdy1;
`ifdef DEMUX_CNT_EN
    logic [15:0]   cnt0, cnt1;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model: per-port FIFO of accepted-but-undelivered beats (capacity 1),
    // last loaded payload per port, and delivery counts.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] last_y[2];
    int unsigned   dlv[2];

    demux1to2_stream #(
        .DATA_WITH (DW)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_data    (data),
        .i_sel     (sel),
        .i_valid   (valid),
        .o_ready   (o_ready),
        .o_y_0     (y0),
        .o_y_1     (y1),
        .o_valid_0 (v0),
        .o_valid_1 (v1),
        .i_ready_0 (rdy0),
        .i_ready_1 (rdy1)
`ifdef DEMUX_CNT_EN
        ,
        .o_cnt_0   (cnt0),
        .o_cnt_1   (cnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, check outputs against the model before the edge,
    // then advance the model across the edge. Returns #1 after the edge.
    task automatic step(input logic r, input logic [DW-1:0] d, input logic s,
                        input logic v, input logic r0, input logic r1);
        logic exp_rdy, acc, del0, del1;
        @(negedge clk);
        rst = r; data = d; sel = s; valid = v; rdy0 = r0; rdy1 = r1;
        #1;
        check("valid_0", v0, q0.size() != 0);
        check("valid_1", v1, q1.size() != 0);
        check("y_0", y0, last_y[0]);
        check("y_1", y1, last_y[1]);
`ifdef DEMUX_CNT_EN
        check("cnt_0", cnt0, dlv[0] % 65536);
        check("cnt_1", cnt1, dlv[1] % 65536);
`endif
        if (r) exp_rdy = 1'b1;
        else if (s == 1'b0) exp_rdy = (q0.size() == 0) || r0;
        else exp_rdy = (q1.size() == 0) || r1;
        check("ready", o_ready, exp_rdy);
        acc  = !r && v && exp_rdy;
        del0 = !r && (q0.size() != 0) && r0;
        del1 = !r && (q1.size() != 0) && r1;
        @(posedge clk);
        if (r) begin
            q0.delete(); q1.delete();
            last_y[0] = '0; last_y[1] = '0;
            dlv[0] = 0; dlv[1] = 0;
        end else begin
            if (del0) begin void'(q0.pop_front()); dlv[0]++; end
            if (del1) begin void'(q1.pop_front()); dlv[1]++; end
            if (acc && s == 1'b0) begin q0.push_back(d); last_y[0] = d; end
            if (acc && s == 1'b1) begin q1.push_back(d); last_y[1] = d; end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; data = '0; sel = 1'b0; valid = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
        last_y[0] = '0; last_y[1] = '0; dlv[0] = 0; dlv[1] = 0;

        // Reset for two cycles, then a first beat to port 0.
        step(1, 8'h00, 0, 0, 0, 0);
        step(1, 8'h00, 0, 0, 0, 0);
        check("rst_v0", v0, 1'b0);
        check("rst_y0", y0, 8'h00);
        step(0, 8'hA5, 0, 1, 1, 1);
        check("first_v0", v0, 1'b1);
        check("first_y0", y0, 8'hA5);
        check("first_v1", v1, 1'b0);
        step(0, 8'h00, 0, 0, 1, 1);
        check("first_v0_gone", v0, 1'b0);

        // Back-to-back alternating beats, both consumers ready.
        step(0, 8'h01, 0, 1, 1, 1);
        check("b2b_y0_01", y0, 8'h01);
        step(0, 8'h02, 1, 1, 1, 1);
        check("b2b_y1_02", y1, 8'h02);
        step(0, 8'h03, 0, 1, 1, 1);
        check("b2b_y0_03", y0, 8'h03);
        step(0, 8'h04, 1, 1, 1, 1);
        check("b2b_y1_04", y1, 8'h04);
        step(0, 8'h00, 0, 0, 1, 1);

        // Stall isolation: port 0 stalled holding 8'h11.
        step(0, 8'h11, 0, 1, 0, 1);
        step(0, 8'h22, 0, 1, 0, 1);
        check("stall_y0", y0, 8'h11);
        check("stall_v0", v0, 1'b1);
        step(0, 8'h33, 1, 1, 0, 1);
        check("stall_y1", y1, 8'h33);
        check("stall_y0_kept", y0, 8'h11);

        // Deliver and reload port 0 on the same edge.
        step(0, 8'h44, 0, 1, 1, 1);
        step(0, 8'h55, 0, 1, 1, 1);
        check("reload_v0", v0, 1'b1);
        check("reload_y0", y0, 8'h55);

        // Reset mid-operation with both ports full and stalled.
        step(0, 8'h66, 1, 1, 0, 0);
        step(0, 8'h77, 0, 1, 1, 0);
        step(0, 8'h00, 0, 0, 0, 0);
        step(1, 8'h88, 0, 1, 0, 0);
        check("midrst_v0", v0, 1'b0);
        check("midrst_v1", v1, 1'b0);
        check("midrst_y0", y0, 8'h00);
        check("midrst_y1", y1, 8'h00);
        step(0, 8'h00, 0, 0, 1, 1);
        step(0, 8'h00, 0, 0, 1, 1);

        // Randomized traffic.
        for (int unsigned i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), DW'($urandom), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end

`ifdef DEMUX_CNT_EN
        // Counter wrap: 65537 deliveries on port 1.
        step(1, 8'h00, 0, 0, 0, 0);
        for (int unsigned i = 0; i < 65537; i++) begin
            step(0, DW'(i), 1, 1, 0, 1);
        end
        step(0, 8'h00, 1, 0, 0, 1);
        check("wrap_cnt1", cnt1, 16'h0001);
        check("wrap_cnt0", cnt0, 16'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
